// File: rtl/gpu_pkg.sv
// Shared GPU definitions: CPU register map, STATUS bit positions and VRAM geometry.
// Used by the CPU bus interface and the pixel-side memory.
package gpu_pkg;

   localparam int unsigned VRAM_AW = 15;

   localparam logic [3:0] REG_ADDR_LO = 4'h0;
   localparam logic [3:0] REG_ADDR_HI = 4'h1;
   localparam logic [3:0] REG_DATA    = 4'h2;
   localparam logic [3:0] REG_INCR    = 4'h3;
   localparam logic [3:0] REG_CTRL    = 4'h4;
   localparam logic [3:0] REG_STATUS  = 4'h5;

   localparam int unsigned STAT_IRQ_PENDING = 0;
   localparam int unsigned STAT_VBLANK_SEEN = 1;
   localparam int unsigned STAT_OVERFLOW    = 2;
   localparam int unsigned STAT_FIFO_EMPTY  = 3;

endpackage

// File: rtl/gpu_write_fifo.sv
// Pending VRAM write queue; occupancy tracked with read/write pointers carrying a wrap bit.
// A push while full is dropped even if a pop happens in the same cycle.
module gpu_write_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gpu_bus_interface.sv
// CPU-facing register block of the GPU: synchronizes the CPU strobe, decodes register
// writes/reads, queues VRAM writes and raises the vblank interrupt.
module gpu_bus_interface #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned VRAM_AW    = gpu_pkg::VRAM_AW
) (
   input  logic               CLK100MHz,
   input  logic               rst,
   input  logic [7:0]         data,
   input  logic [3:0]         addr,
   input  logic               rw,
   input  logic               cs_clock,
   input  logic               vblank_start,
   input  logic               wr_ready,
   output logic               wr_en,
   output logic [VRAM_AW-1:0] wr_addr,
   output logic [7:0]         wr_data,
   output logic [7:0]         data_out,
   output logic               data_oe,
   output logic               irq
);

   import gpu_pkg::*;

   logic               cs_s1, cs_s2, cs_s3;
   logic               cs_fall;
   logic [7:0]         lat_data;
   logic [3:0]         lat_addr;
   logic               lat_rw;
   logic               wr_commit, rd_commit;

   logic [VRAM_AW-1:0] pointer, ptr_nxt;
   logic [7:0]         incr, incr_nxt;
   logic               ctrl, ctrl_nxt;
   logic               irq_pending, irq_pending_nxt;
   logic               vblank_seen, vblank_seen_nxt;
   logic               overflow, overflow_nxt;
   logic               push, irq_clr, ovf_clr, rd_status;

   logic               fifo_full, fifo_empty;
   logic [VRAM_AW+7:0] fifo_head;
   logic [7:0]         status;

   assign cs_fall   = !cs_s2 && cs_s3;
   assign wr_commit = cs_fall && !lat_rw;
   assign rd_commit = cs_fall && lat_rw;
   assign rd_status = rd_commit && (lat_addr == REG_STATUS);

   always_ff @(posedge CLK100MHz) begin
      if (!rst) begin
         cs_s1    <= 1'b0;
         cs_s2    <= 1'b0;
         cs_s3    <= 1'b0;
         lat_data <= '0;
         lat_addr <= '0;
         lat_rw   <= 1'b1;
      end else begin
         cs_s1 <= cs_clock;
         cs_s2 <= cs_s1;
         cs_s3 <= cs_s2;
         if (cs_s2) begin
            lat_data <= data;
            lat_addr <= addr;
            lat_rw   <= rw;
         end
      end
   end

   always_comb begin
      ptr_nxt  = pointer;
      incr_nxt = incr;
      ctrl_nxt = ctrl;
      push     = 1'b0;
      irq_clr  = 1'b0;
      ovf_clr  = 1'b0;
      if (wr_commit) begin
         case (lat_addr)
            REG_ADDR_LO: ptr_nxt[7:0] = lat_data;
            REG_ADDR_HI: ptr_nxt[VRAM_AW-1:8] = lat_data[VRAM_AW-9:0];
            REG_DATA: begin
               push    = 1'b1;
               ptr_nxt = pointer + {{(VRAM_AW-8){1'b0}}, incr};
            end
            REG_INCR:   incr_nxt = lat_data;
            REG_CTRL:   ctrl_nxt = lat_data[0];
            REG_STATUS: begin
               irq_clr = lat_data[STAT_IRQ_PENDING];
               ovf_clr = lat_data[STAT_OVERFLOW];
            end
            default: ;
         endcase
      end
   end

   // Set terms are ORed in last so they win over a same-cycle clear.
   always_comb begin
      irq_pending_nxt = (irq_pending && !irq_clr) || (vblank_start && ctrl);
      vblank_seen_nxt = (vblank_seen && !rd_status) || vblank_start;
      overflow_nxt    = (overflow && !ovf_clr) || (push && fifo_full);
   end

   always_ff @(posedge CLK100MHz) begin
      if (!rst) begin
         pointer     <= '0;
         incr        <= 8'h01;
         ctrl        <= 1'b0;
         irq_pending <= 1'b0;
         vblank_seen <= 1'b0;
         overflow    <= 1'b0;
         irq         <= 1'b0;
      end else begin
         pointer     <= ptr_nxt;
         incr        <= incr_nxt;
         ctrl        <= ctrl_nxt;
         irq_pending <= irq_pending_nxt;
         vblank_seen <= vblank_seen_nxt;
         overflow    <= overflow_nxt;
         irq         <= irq_pending_nxt && ctrl_nxt;
      end
   end

   gpu_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (VRAM_AW + 8)
   ) u_fifo (
      .clk   (CLK100MHz),
      .rst   (rst),
      .push  (push),
      .pop   (wr_en && wr_ready),
      .din   ({pointer, lat_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign wr_en   = !fifo_empty;
   assign wr_addr = fifo_head[8 +: VRAM_AW];
   assign wr_data = fifo_head[7:0];

   always_comb begin
      status                   = '0;
      status[STAT_IRQ_PENDING] = irq_pending;
      status[STAT_VBLANK_SEEN] = vblank_seen;
      status[STAT_OVERFLOW]    = overflow;
      status[STAT_FIFO_EMPTY]  = fifo_empty;
   end

   assign data_oe = cs_clock && rw;

   always_comb begin
      data_out = '0;
      case (addr)
         REG_ADDR_LO: data_out = pointer[7:0];
         REG_ADDR_HI: data_out = 8'(pointer >> 8);
         REG_INCR:    data_out = incr;
         REG_CTRL:    data_out = {7'b0, ctrl};
         REG_STATUS:  data_out = status;
         default:     data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_gpu_bus_interface.sv
// Directed bench for gpu_bus_interface: register table plus hand-built FIFO, IRQ and reset sequences.
module tb_gpu_bus_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data;
   logic [3:0]  addr;
   logic        rw;
   logic        cs_clock;
   logic        vblank_start;
   logic        wr_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        irq;

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [22:0] vram_q[$];
   logic [22:0] exp_q[$];

   always #5 clk = ~clk;

   gpu_bus_interface #(
      .FIFO_DEPTH (4),
      .VRAM_AW    (15)
   ) dut (
      .CLK100MHz    (clk),
      .rst          (rst),
      .data         (data),
      .addr         (addr),
      .rw           (rw),
      .cs_clock     (cs_clock),
      .vblank_start (vblank_start),
      .wr_ready     (wr_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .data_out     (data_out),
      .data_oe      (data_oe),
      .irq          (irq)
   );

   // A pop seen at the falling edge completes at the following rising edge.
   always @(negedge clk) begin
      if (rst && wr_en && wr_ready) vram_q.push_back({wr_addr, wr_data});
   end

   typedef struct {
      logic       is_rd;
      logic [3:0] a;
      logic [7:0] d;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      addr = a; data = d; rw = 1'b0; cs_clock = 1'b1;
      repeat (4) @(posedge clk);
      #1 cs_clock = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
      addr = a; data = 8'h00; rw = 1'b1; cs_clock = 1'b1;
      repeat (4) @(posedge clk);
      #1 d = data_out; oe = data_oe;
      cs_clock = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       oe;
      bus_read(a, d, oe);
      check(name, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic check_vram(input string name);
      check({name, "_count"}, vram_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < vram_q.size(); i++)
         check($sformatf("%s_entry%0d", name, i), {9'h0, vram_q[i]}, {9'h0, exp_q[i]});
   endtask

   initial begin
      logic [7:0] rd;
      logic       oe;

      rst = 1'b0; data = '0; addr = '0; rw = 1'b0; cs_clock = 1'b0;
      vblank_start = 1'b0; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("rst_wr_en", {31'h0, wr_en}, 0);
      check("rst_irq", {31'h0, irq}, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("idle_oe", {31'h0, data_oe}, 0);
      read_check("rst_addr_lo", gpu_pkg::REG_ADDR_LO, 8'h00);
      read_check("rst_addr_hi", gpu_pkg::REG_ADDR_HI, 8'h00);
      read_check("rst_incr",    gpu_pkg::REG_INCR,    8'h01);
      read_check("rst_ctrl",    gpu_pkg::REG_CTRL,    8'h00);
      read_check("rst_status",  gpu_pkg::REG_STATUS,  8'h08);

      // Register write/readback table: d is write data or expected read data.
      vecs = '{
         '{1'b0, 4'h3, 8'h05}, '{1'b1, 4'h3, 8'h05},
         '{1'b0, 4'h0, 8'h34}, '{1'b1, 4'h0, 8'h34},
         '{1'b0, 4'h1, 8'hFF}, '{1'b1, 4'h1, 8'h7F},
         '{1'b0, 4'h4, 8'hFF}, '{1'b1, 4'h4, 8'h01},
         '{1'b0, 4'h4, 8'h00}, '{1'b1, 4'h4, 8'h00},
         '{1'b0, 4'h9, 8'h55}, '{1'b1, 4'h9, 8'h00},
         '{1'b1, 4'hF, 8'h00}, '{1'b1, 4'h0, 8'h34},
         '{1'b1, 4'h5, 8'h08},
         '{1'b0, 4'h3, 8'h01}, '{1'b1, 4'h3, 8'h01}
      };
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_rd) begin
            bus_read(vecs[i].a, rd, oe);
            check($sformatf("vec%0d_rd_a%h", i, vecs[i].a), {24'h0, rd}, {24'h0, vecs[i].d});
            check($sformatf("vec%0d_oe", i), {31'h0, oe}, 1);
         end else begin
            bus_write(vecs[i].a, vecs[i].d);
         end
      end

      // Pointer wrap at top of VRAM.
      vram_q.delete();
      bus_write(gpu_pkg::REG_ADDR_LO, 8'hFE);
      bus_write(gpu_pkg::REG_ADDR_HI, 8'h7F);
      bus_write(gpu_pkg::REG_INCR, 8'h01);
      bus_write(gpu_pkg::REG_DATA, 8'hAA);
      bus_write(gpu_pkg::REG_DATA, 8'hBB);
      repeat (3) @(posedge clk); #1;
      exp_q = '{{15'h7FFE, 8'hAA}, {15'h7FFF, 8'hBB}};
      check_vram("wrap");
      read_check("wrap_addr_lo", gpu_pkg::REG_ADDR_LO, 8'h00);
      read_check("wrap_addr_hi", gpu_pkg::REG_ADDR_HI, 8'h00);

      // INCR=0 keeps hitting the same address.
      vram_q.delete();
      bus_write(gpu_pkg::REG_ADDR_LO, 8'h23);
      bus_write(gpu_pkg::REG_ADDR_HI, 8'h01);
      bus_write(gpu_pkg::REG_INCR, 8'h00);
      bus_write(gpu_pkg::REG_DATA, 8'h01);
      bus_write(gpu_pkg::REG_DATA, 8'h02);
      bus_write(gpu_pkg::REG_DATA, 8'h03);
      repeat (3) @(posedge clk); #1;
      exp_q = '{{15'h0123, 8'h01}, {15'h0123, 8'h02}, {15'h0123, 8'h03}};
      check_vram("incr0");
      read_check("incr0_addr_lo", gpu_pkg::REG_ADDR_LO, 8'h23);
      read_check("incr0_addr_hi", gpu_pkg::REG_ADDR_HI, 8'h01);
      bus_write(gpu_pkg::REG_INCR, 8'h01);

      // Overflow: fifth write is dropped but the pointer still advances.
      vram_q.delete();
      wr_ready = 1'b0;
      bus_write(gpu_pkg::REG_ADDR_LO, 8'h10);
      bus_write(gpu_pkg::REG_ADDR_HI, 8'h02);
      for (int i = 1; i <= 5; i++) bus_write(gpu_pkg::REG_DATA, 8'(i * 8'h11));
      check("ovf_wr_en", {31'h0, wr_en}, 1);
      check("ovf_head", {9'h0, wr_addr, wr_data}, {9'h0, 15'h0210, 8'h11});
      read_check("ovf_status", gpu_pkg::REG_STATUS, 8'h04);
      read_check("ovf_addr_lo", gpu_pkg::REG_ADDR_LO, 8'h15);
      wr_ready = 1'b1;
      repeat (8) @(posedge clk); #1;
      exp_q = '{{15'h0210, 8'h11}, {15'h0211, 8'h22}, {15'h0212, 8'h33}, {15'h0213, 8'h44}};
      check_vram("ovf_drain");
      read_check("ovf_status_drained", gpu_pkg::REG_STATUS, 8'h0C);
      bus_write(gpu_pkg::REG_STATUS, 8'h04);
      read_check("ovf_status_cleared", gpu_pkg::REG_STATUS, 8'h08);

      // vblank IRQ with enable set; set beats a same-cycle clear.
      bus_write(gpu_pkg::REG_CTRL, 8'h01);
      vblank_start = 1'b1;
      @(posedge clk); #1 vblank_start = 1'b0;
      check("irq_set", {31'h0, irq}, 1);
      bus_write(gpu_pkg::REG_STATUS, 8'h01);
      check("irq_clr", {31'h0, irq}, 0);
      addr = gpu_pkg::REG_STATUS; data = 8'h01; rw = 1'b0; cs_clock = 1'b1;
      repeat (4) @(posedge clk);
      #1 cs_clock = 1'b0;
      repeat (2) @(posedge clk);
      #1 vblank_start = 1'b1;
      @(posedge clk); #1 vblank_start = 1'b0;
      check("irq_set_wins", {31'h0, irq}, 1);
      repeat (3) @(posedge clk); #1;
      check("irq_still_set", {31'h0, irq}, 1);
      bus_write(gpu_pkg::REG_STATUS, 8'h01);
      check("irq_clr2", {31'h0, irq}, 0);

      // vblank with enable clear: only vblank_seen, cleared by a STATUS read.
      bus_write(gpu_pkg::REG_CTRL, 8'h00);
      read_check("vbl_status_pre", gpu_pkg::REG_STATUS, 8'h0A);
      read_check("vbl_status_clr", gpu_pkg::REG_STATUS, 8'h08);
      vblank_start = 1'b1;
      @(posedge clk); #1 vblank_start = 1'b0;
      @(posedge clk); #1;
      check("vbl_irq_off", {31'h0, irq}, 0);
      read_check("vbl_status_seen", gpu_pkg::REG_STATUS, 8'h0A);
      read_check("vbl_status_after", gpu_pkg::REG_STATUS, 8'h08);

      // Reset with queued entries and an in-flight strobe.
      vram_q.delete();
      wr_ready = 1'b0;
      bus_write(gpu_pkg::REG_INCR, 8'h07);
      for (int i = 0; i < 3; i++) bus_write(gpu_pkg::REG_DATA, 8'(8'hC0 + i));
      check("rstq_wr_en_pre", {31'h0, wr_en}, 1);
      addr = gpu_pkg::REG_DATA; data = 8'hEE; rw = 1'b0; cs_clock = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rstq_wr_en", {31'h0, wr_en}, 0);
      cs_clock = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; wr_ready = 1'b1;
      repeat (10) @(posedge clk); #1;
      exp_q.delete();
      check_vram("rstq");
      read_check("rstq_incr", gpu_pkg::REG_INCR, 8'h01);
      read_check("rstq_status", gpu_pkg::REG_STATUS, 8'h08);
      check("rstq_irq", {31'h0, irq}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
